// File: rtl/beta_dac_pkg.sv
// Shared definitions for the beta unary segment of the DAC digital path.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package beta_dac_pkg;

  localparam int BETA_THERM_W = 6;
  localparam int BETA_BIN_W   = 3;

  // The seven legal beta thermometer words; bit 0 is the first element enabled.
  localparam logic [BETA_THERM_W-1:0] BETA_T0 = 6'b000000;
  localparam logic [BETA_THERM_W-1:0] BETA_T1 = 6'b000001;
  localparam logic [BETA_THERM_W-1:0] BETA_T2 = 6'b000011;
  localparam logic [BETA_THERM_W-1:0] BETA_T3 = 6'b000111;
  localparam logic [BETA_THERM_W-1:0] BETA_T4 = 6'b001111;
  localparam logic [BETA_THERM_W-1:0] BETA_T5 = 6'b011111;
  localparam logic [BETA_THERM_W-1:0] BETA_T6 = 6'b111111;

  // Number of enabled elements in a word: the level the DAC actually drives,
  // whether or not the word is a clean thermometer code.
  function automatic logic [BETA_BIN_W-1:0] beta_ones(input logic [BETA_THERM_W-1:0] w);
    logic [BETA_BIN_W-1:0] n;
    n = '0;
    for (int i = 0; i < BETA_THERM_W; i++) begin
      n = n + {{(BETA_BIN_W-1){1'b0}}, w[i]};
    end
    return n;
  endfunction

  // Forward mapping used by the 3-to-6 decoder; codes above 6 clamp to full scale.
  function automatic logic [BETA_THERM_W-1:0] beta_bin2therm(input logic [BETA_BIN_W-1:0] b);
    logic [BETA_THERM_W-1:0] t;
    t = '0;
    for (int i = 0; i < BETA_THERM_W; i++) begin
      t[i] = (BETA_BIN_W'(i) < b);
    end
    return t;
  endfunction

endpackage

// File: rtl/therm6_enc_core.sv
// Combinational 6-bit thermometer to 3-bit binary encoder with bubble detect.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Bubble words encode to 0, or to their ones count when THERM_BUBBLE_CORRECT_EN is defined.
module therm6_enc_core
  import beta_dac_pkg::*;
(
  input  logic [BETA_THERM_W-1:0] therm,
  output logic [BETA_BIN_W-1:0]   bin,
  output logic                    bubble
);

  // Exact match against the legal codes; anything else is a bubble.
  always_comb begin
    bin    = '0;
    bubble = 1'b0;
    case (therm)
      BETA_T0: bin = 3'd0;
      BETA_T1: bin = 3'd1;
      BETA_T2: bin = 3'd2;
      BETA_T3: bin = 3'd3;
      BETA_T4: bin = 3'd4;
      BETA_T5: bin = 3'd5;
      BETA_T6: bin = 3'd6;
      default: begin
        bubble = 1'b1;
`ifdef THERM_BUBBLE_CORRECT_EN
        // Report the level the DAC really produced for the broken word.
        bin = beta_ones(therm);
`else
        bin = '0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/therm6_to_bin3_beta.sv
// Registered beta thermometer readback encoder with bubble flag, saturating error count and sticky flag.
// Latency: 2 cycles, one word per cycle. Backpressure: none; every valid input yields one out_valid.
// Optional THERM_BUBBLE_CORRECT_EN: bubble words report their ones count instead of 0.
module therm6_to_bin3_beta
  import beta_dac_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BETA_THERM_W-1:0] therm_in,
  input  logic                    in_valid,
  input  logic                    clr_err,
  output logic [BETA_BIN_W-1:0]   bin_out,
  output logic                    out_valid,
  output logic                    bubble_err,
  output logic [CNT_W-1:0]        err_cnt,
  output logic                    err_sticky
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [BETA_THERM_W-1:0] s1_therm;
  logic                    s1_valid;
  logic [BETA_BIN_W-1:0]   enc_bin;
  logic                    enc_bubble;
  logic                    bubble_evt;

  therm6_enc_core u_enc (
    .therm  (s1_therm),
    .bin    (enc_bin),
    .bubble (enc_bubble)
  );

  // A bubble word is being committed into stage 2 this cycle.
  assign bubble_evt = s1_valid & enc_bubble;

  // Stage 1: capture the raw word and its valid every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_therm <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_therm <= therm_in;
      s1_valid <= in_valid;
    end
  end

  // Stage 2: register the encoded result; data holds through idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_out    <= '0;
      bubble_err <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        bin_out    <= enc_bin;
        bubble_err <= enc_bubble;
      end
    end
  end

  // Error bookkeeping; a bubble arriving with clr_err counts as the first error after the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clr_err) begin
      err_cnt    <= bubble_evt ? CNT_ONE : '0;
      err_sticky <= bubble_evt;
    end else if (bubble_evt) begin
      err_sticky <= 1'b1;
      if (err_cnt != CNT_MAX) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_therm6_to_bin3_beta.sv
// Self-checking bench for therm6_to_bin3_beta: vector table plus scoreboard queue,
// with hand-written sequences for gaps, saturation, clear collision and mid-stream reset.
module tb_therm6_to_bin3_beta;

`ifdef THERM_BUBBLE_CORRECT_EN
  localparam bit CORR = 1'b1;
`else
  localparam bit CORR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] therm_in;
  logic       in_valid;
  logic       clr_err;
  logic [2:0] bin_out;
  logic       out_valid;
  logic       bubble_err;
  logic [7:0] err_cnt;
  logic       err_sticky;

  always #5 clk = ~clk;

  therm6_to_bin3_beta #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .therm_in   (therm_in),
    .in_valid   (in_valid),
    .clr_err    (clr_err),
    .bin_out    (bin_out),
    .out_valid  (out_valid),
    .bubble_err (bubble_err),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky)
  );

  typedef struct {
    logic [5:0] therm;
    logic [2:0] bin;
    logic       bub;
  } vec_t;

  typedef struct {
    logic [2:0] bin;
    logic       bub;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];
  int   nchk   = 0;
  int   nerr   = 0;
  int   npulse = 0;
  int   npush  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, for sampling on the next one.
  task automatic drive(input logic [5:0] t, input logic v, input logic c, input logic r);
    @(posedge clk);
    #1;
    therm_in = t;
    in_valid = v;
    clr_err  = c;
    rst_n    = r;
  endtask

  task automatic send(input vec_t v);
    drive(v.therm, 1'b1, 1'b0, 1'b1);
    sb.push_back('{v.bin, v.bub});
    npush++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(6'b000000, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    vecs[0] = '{6'b000000, 3'd0, 1'b0};
    vecs[1] = '{6'b000001, 3'd1, 1'b0};
    vecs[2] = '{6'b000011, 3'd2, 1'b0};
    vecs[3] = '{6'b000111, 3'd3, 1'b0};
    vecs[4] = '{6'b001111, 3'd4, 1'b0};
    vecs[5] = '{6'b011111, 3'd5, 1'b0};
    vecs[6] = '{6'b111111, 3'd6, 1'b0};
    vecs[7] = '{6'b000101, CORR ? 3'd2 : 3'd0, 1'b1};
    vecs[8] = '{6'b110000, CORR ? 3'd2 : 3'd0, 1'b1};
    vecs[9] = '{6'b101010, CORR ? 3'd3 : 3'd0, 1'b1};

    rst_n = 1'b0; therm_in = '0; in_valid = 1'b0; clr_err = 1'b0;

    // Output monitor: every out_valid pulse must match the oldest expectation.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (out_valid === 1'b1) begin
          npulse++;
          if (sb.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_out_valid: got bin_out=%0d, expected no output (t=%0t)", bin_out, $time);
          end else begin
            e = sb.pop_front();
            chk("bin_out", 32'(bin_out), 32'(e.bin));
            chk("bubble_err", 32'(bubble_err), 32'(e.bub));
          end
        end
      end
    join_none

    // Reset state.
    drive(6'b111111, 1'b1, 1'b1, 1'b0);
    drive(6'b000000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_bin_out", 32'(bin_out), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_bubble_err", 32'(bubble_err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_err_sticky", 32'(err_sticky), 0);
    idle(2);

    // Legal sweep, back to back.
    for (int i = 0; i < 7; i++) send(vecs[i]);
    idle(4);
    chk("sweep_err_cnt", 32'(err_cnt), 0);
    chk("sweep_err_sticky", 32'(err_sticky), 0);

    // Single bubble.
    send(vecs[7]);
    idle(4);
    chk("bubble1_err_cnt", 32'(err_cnt), 1);
    chk("bubble1_err_sticky", 32'(err_sticky), 1);

    // Remaining bubble patterns.
    for (int i = 8; i < 10; i++) send(vecs[i]);
    idle(4);
    chk("bubble3_err_cnt", 32'(err_cnt), 3);

    // Gapped stream: valid, idle, valid.
    send(vecs[2]);
    idle(1);
    send(vecs[4]);
    @(negedge clk);
    chk("gap_vld0", 32'(out_valid), 1);
    chk("gap_bin0", 32'(bin_out), 2);
    idle(1);
    @(negedge clk);
    chk("gap_vld1", 32'(out_valid), 0);
    chk("gap_bin_hold", 32'(bin_out), 2);
    idle(1);
    @(negedge clk);
    chk("gap_vld2", 32'(out_valid), 1);
    chk("gap_bin2", 32'(bin_out), 4);
    idle(3);

    // Saturation.
    for (int i = 0; i < 300; i++) send(vecs[7 + (i % 3)]);
    idle(4);
    chk("sat_err_cnt", 32'(err_cnt), 255);
    chk("sat_err_sticky", 32'(err_sticky), 1);
    for (int i = 0; i < 3; i++) send(vecs[7]);
    idle(4);
    chk("sat_hold_err_cnt", 32'(err_cnt), 255);

    // clr_err on the cycle the bubble enters stage 2.
    send(vecs[9]);
    drive(6'b000000, 1'b0, 1'b1, 1'b1);
    drive(6'b000000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("clr_hit_err_cnt", 32'(err_cnt), 1);
    chk("clr_hit_err_sticky", 32'(err_sticky), 1);
    drive(6'b000000, 1'b0, 1'b1, 1'b1);
    drive(6'b000000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("clr_alone_err_cnt", 32'(err_cnt), 0);
    chk("clr_alone_err_sticky", 32'(err_sticky), 0);
    idle(3);

    // Mid-stream reset: load non-zero state first, then discard two words in flight.
    send(vecs[8]);
    idle(3);
    send(vecs[5]);
    idle(3);
    chk("pre_rst_bin_out", 32'(bin_out), 5);
    chk("pre_rst_err_cnt", 32'(err_cnt), 1);
    drive(vecs[3].therm, 1'b1, 1'b0, 1'b1);
    drive(vecs[6].therm, 1'b1, 1'b0, 1'b0);
    drive(6'b000000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("mid_rst_bin_out", 32'(bin_out), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_bubble_err", 32'(bubble_err), 0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 0);
    chk("mid_rst_err_sticky", 32'(err_sticky), 0);
    idle(5);

    chk("scoreboard_empty", 32'(sb.size()), 0);
    chk("pulse_count", 32'(npulse), 32'(npush));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
